// File: rtl/s27_resp_misr_if.sv
`default_nettype none
// ============================================================================
//  Module      : s27_resp_misr_if
//  Description : Control, response and status bundle between the BIST
//                harness (master) and the s27 response analyser (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface s27_resp_misr_if #(
    parameter int W = 16
) ();

    logic         START;
    logic         ABORT;
    logic         G17;
    logic [W-1:0] GOLDEN;
    logic         BUSY;
    logic         DONE;
    logic         PASS;
    logic [W-1:0] SIG;

    // Harness side: requests runs, supplies the response bit and golden value
    modport master (
        output START,
        output ABORT,
        output G17,
        output GOLDEN,
        input  BUSY,
        input  DONE,
        input  PASS,
        input  SIG
    );

    // Analyser side
    modport slave (
        input  START,
        input  ABORT,
        input  G17,
        input  GOLDEN,
        output BUSY,
        output DONE,
        output PASS,
        output SIG
    );

endinterface
`default_nettype wire

// File: rtl/s27_resp_misr.sv
`default_nettype none
// ============================================================================
//  Module      : s27_resp_misr
//  Description : BIST response analyser for the s27 core. Waits SKIP settle
//                cycles after START, compacts N samples of G17 into a W-bit
//                MISR, then compares the signature against GOLDEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module s27_resp_misr #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = W'(16'h002D),
    parameter logic [W-1:0] SEED = '0,
    parameter int           N    = 64,
    parameter int           SKIP = 3
) (
    input  wire logic            CK,
    input  wire logic            RN,
    s27_resp_misr_if.slave       bus
);

    // Counter is wide enough to hold max(N,SKIP) so it never wraps in a run
    localparam int C_MAXC = (N > SKIP) ? N : SKIP;
    localparam int C_CW   = $clog2(C_MAXC) + 1;

    localparam logic [C_CW-1:0] C_N_LAST    = C_CW'(N - 1);
    localparam logic [C_CW-1:0] C_SKIP_LAST = C_CW'((SKIP > 0) ? (SKIP - 1) : 0);
    localparam logic [C_CW-1:0] C_CNT_ONE   = C_CW'(1);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_SETTLE = 2'd1;
    localparam logic [1:0] C_ST_RUN    = 2'd2;
    localparam logic [1:0] C_ST_DONE   = 2'd3;

    // First state after an accepted START depends on whether a settle window exists
    localparam logic [1:0] C_ST_FIRST  = (SKIP > 0) ? C_ST_SETTLE : C_ST_RUN;

    logic [1:0]      state_q, state_d;
    logic [C_CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]    sig_q,   sig_d;
    logic            pass_q,  pass_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [W-1:0]    misr_next;

    // One MISR step: shift left, fold in taps on MSB, inject G17 at bit 0
    always_comb begin
        misr_next = {sig_q[W-2:0], bus.G17} ^ (sig_q[W-1] ? POLY : '0);
    end

    // State register plus all datapath flops; RN clears everything at once
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= C_ST_IDLE;
            cnt_q   <= '0;
            sig_q   <= SEED;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update; ABORT overrides every other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        pass_d  = pass_q;

        if (bus.ABORT) begin
            // SIG deliberately holds so the harness can inspect a partial signature
            state_d = C_ST_IDLE;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                C_ST_IDLE, C_ST_DONE: begin
                    if (bus.START) begin
                        state_d = C_ST_FIRST;
                        cnt_d   = '0;
                        sig_d   = SEED;
                        pass_d  = 1'b0;
                    end
                end
                C_ST_SETTLE: begin
                    // G17 is ignored while the core's flops initialise
                    if (cnt_q == C_SKIP_LAST) begin
                        state_d = C_ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + C_CNT_ONE;
                    end
                end
                C_ST_RUN: begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + C_CNT_ONE;
                    if (cnt_q == C_N_LAST) begin
                        state_d = C_ST_DONE;
                        pass_d  = (misr_next == bus.GOLDEN);
                    end
                end
                default: begin
                    state_d = C_ST_IDLE;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    // Status decode from the next state so BUSY/DONE come straight from flops
    always_comb begin
        busy_d = (state_d == C_ST_SETTLE) || (state_d == C_ST_RUN);
        done_d = (state_d == C_ST_DONE);
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.PASS = pass_q;
    assign bus.SIG  = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_s27_resp_misr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s27_resp_misr
//  Description : Directed bench for s27_resp_misr using three configurations
//                (SKIP=0/N=4, SKIP=0/N=5, SKIP=3/N=4) at W=4, POLY=4'h3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_s27_resp_misr;

    logic CK;
    logic RN;

    int total;
    int bad;

    s27_resp_misr_if #(.W(4)) bus0 ();
    s27_resp_misr_if #(.W(4)) bus1 ();
    s27_resp_misr_if #(.W(4)) bus2 ();

    s27_resp_misr #(.W(4), .POLY(4'h3), .SEED(4'h0), .N(4), .SKIP(0)) u_dut0 (
        .CK  (CK),
        .RN  (RN),
        .bus (bus0)
    );

    s27_resp_misr #(.W(4), .POLY(4'h3), .SEED(4'h0), .N(5), .SKIP(0)) u_dut1 (
        .CK  (CK),
        .RN  (RN),
        .bus (bus1)
    );

    s27_resp_misr #(.W(4), .POLY(4'h3), .SEED(4'h0), .N(4), .SKIP(3)) u_dut2 (
        .CK  (CK),
        .RN  (RN),
        .bus (bus2)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RN    = 1'b0;
        bus0.START = 1'b0; bus0.ABORT = 1'b0; bus0.G17 = 1'b0; bus0.GOLDEN = 4'hB;
        bus1.START = 1'b0; bus1.ABORT = 1'b0; bus1.G17 = 1'b0; bus1.GOLDEN = 4'hC;
        bus2.START = 1'b0; bus2.ABORT = 1'b0; bus2.G17 = 1'b0; bus2.GOLDEN = 4'h0;

        step();
        step();
        chk("rst_busy", {31'd0, bus0.BUSY}, 32'd0);
        chk("rst_done", {31'd0, bus0.DONE}, 32'd0);
        chk("rst_pass", {31'd0, bus0.PASS}, 32'd0);
        chk("rst_sig",  {28'd0, bus0.SIG},  32'h0);
        RN = 1'b1;
        step();

        // ---- run A: G17 = 1,0,1,1 -> SIG 1,2,5,B, GOLDEN=B ----
        bus0.START = 1'b1;
        step();
        bus0.START = 1'b0;
        chk("a_busy_after_start", {31'd0, bus0.BUSY}, 32'd1);
        chk("a_sig_seed", {28'd0, bus0.SIG}, 32'h0);
        bus0.G17 = 1'b1; step(); chk("a_sig1", {28'd0, bus0.SIG}, 32'h1);
        bus0.G17 = 1'b0; step(); chk("a_sig2", {28'd0, bus0.SIG}, 32'h2);
        bus0.G17 = 1'b1; step(); chk("a_sig3", {28'd0, bus0.SIG}, 32'h5);
        chk("a_done_early", {31'd0, bus0.DONE}, 32'd0);
        bus0.G17 = 1'b1; step(); chk("a_sig4", {28'd0, bus0.SIG}, 32'hB);
        chk("a_done", {31'd0, bus0.DONE}, 32'd1);
        chk("a_busy_end", {31'd0, bus0.BUSY}, 32'd0);
        chk("a_pass", {31'd0, bus0.PASS}, 32'd1);
        bus0.G17 = 1'b0;
        step(); step();
        chk("a_hold_sig", {28'd0, bus0.SIG}, 32'hB);
        chk("a_hold_pass", {31'd0, bus0.PASS}, 32'd1);

        // ---- run B: back-to-back restart from DONE, GOLDEN=A -> PASS=0 ----
        bus0.GOLDEN = 4'hA;
        bus0.START  = 1'b1;
        step();
        bus0.START  = 1'b0;
        chk("b_sig_reload", {28'd0, bus0.SIG}, 32'h0);
        chk("b_pass_clear", {31'd0, bus0.PASS}, 32'd0);
        chk("b_done_clear", {31'd0, bus0.DONE}, 32'd0);
        bus0.G17 = 1'b1; step();
        bus0.G17 = 1'b0; step();
        bus0.G17 = 1'b1; step();
        bus0.G17 = 1'b1; step();
        bus0.G17 = 1'b0;
        chk("b_sig_final", {28'd0, bus0.SIG}, 32'hB);
        chk("b_done", {31'd0, bus0.DONE}, 32'd1);
        chk("b_pass_wrong_golden", {31'd0, bus0.PASS}, 32'd0);

        // ---- run C: N=5, all ones -> 1,3,7,F,C with feedback on step 5 ----
        bus1.START = 1'b1;
        step();
        bus1.START = 1'b0;
        bus1.G17   = 1'b1;
        step(); chk("c_sig1", {28'd0, bus1.SIG}, 32'h1);
        step(); chk("c_sig2", {28'd0, bus1.SIG}, 32'h3);
        step(); chk("c_sig3", {28'd0, bus1.SIG}, 32'h7);
        step(); chk("c_sig4", {28'd0, bus1.SIG}, 32'hF);
        chk("c_done_early", {31'd0, bus1.DONE}, 32'd0);
        step(); chk("c_sig5", {28'd0, bus1.SIG}, 32'hC);
        chk("c_done", {31'd0, bus1.DONE}, 32'd1);
        chk("c_pass", {31'd0, bus1.PASS}, 32'd1);
        bus1.G17 = 1'b0;

        // ---- run D: SKIP=3, N=4; ones during settle, zeros during run ----
        bus2.START = 1'b1;
        step();
        bus2.START = 1'b0;
        chk("d_busy_start", {31'd0, bus2.BUSY}, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            bus2.G17 = (i <= 3) ? 1'b1 : 1'b0;
            step();
            if (i < 7) begin
                chk($sformatf("d_busy_%0d", i), {30'd0, bus2.BUSY, bus2.DONE}, 32'h2);
            end
        end
        bus2.G17 = 1'b0;
        chk("d_done_at_7", {31'd0, bus2.DONE}, 32'd1);
        chk("d_busy_off", {31'd0, bus2.BUSY}, 32'd0);
        chk("d_sig_zero", {28'd0, bus2.SIG}, 32'h0);
        chk("d_pass", {31'd0, bus2.PASS}, 32'd1);

        // ---- run E: START during BUSY ignored, then ABORT on RUN cycle 2 ----
        bus0.GOLDEN = 4'hB;
        bus0.START  = 1'b1;
        step();
        bus0.G17    = 1'b1;
        step();
        chk("e_start_ignored_sig", {28'd0, bus0.SIG}, 32'h1);
        chk("e_start_ignored_busy", {31'd0, bus0.BUSY}, 32'd1);
        bus0.START = 1'b0;
        bus0.ABORT = 1'b1;
        step();
        bus0.ABORT = 1'b0;
        chk("e_abort_busy", {31'd0, bus0.BUSY}, 32'd0);
        chk("e_abort_done", {31'd0, bus0.DONE}, 32'd0);
        chk("e_abort_sig_hold", {28'd0, bus0.SIG}, 32'h1);
        step();
        chk("e_idle_stays", {31'd0, bus0.BUSY}, 32'd0);

        // ---- run F: simultaneous START and ABORT, ABORT wins ----
        bus0.START = 1'b1;
        bus0.ABORT = 1'b1;
        step();
        bus0.START = 1'b0;
        bus0.ABORT = 1'b0;
        chk("f_abort_wins", {31'd0, bus0.BUSY}, 32'd0);

        // ---- run G: ABORT on the final RUN edge beats the DONE transition ----
        bus0.START = 1'b1;
        step();
        bus0.START = 1'b0;
        bus0.G17   = 1'b1; step(); step(); step();
        bus0.ABORT = 1'b1;
        step();
        bus0.ABORT = 1'b0;
        chk("g_abort_over_done", {30'd0, bus0.BUSY, bus0.DONE}, 32'h0);
        chk("g_abort_pass", {31'd0, bus0.PASS}, 32'd0);

        // ---- run H: asynchronous reset mid-run, then full clean run ----
        bus0.START = 1'b1;
        step();
        bus0.START = 1'b0;
        bus0.G17   = 1'b1;
        step();
        step();
        chk("h_sig_before_rst", {28'd0, bus0.SIG}, 32'h3);
        #2;
        RN = 1'b0;
        #1;
        chk("h_async_busy", {31'd0, bus0.BUSY}, 32'd0);
        chk("h_async_sig", {28'd0, bus0.SIG}, 32'h0);
        #2;
        RN = 1'b1;
        step();
        bus0.START = 1'b1;
        step();
        bus0.START = 1'b0;
        bus0.G17 = 1'b1; step();
        bus0.G17 = 1'b0; step();
        bus0.G17 = 1'b1; step();
        bus0.G17 = 1'b1; step();
        bus0.G17 = 1'b0;
        chk("h_sig_after_rst", {28'd0, bus0.SIG}, 32'hB);
        chk("h_done_after_rst", {31'd0, bus0.DONE}, 32'd1);
        chk("h_pass_after_rst", {31'd0, bus0.PASS}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s27_resp_misr.md
Name: s27_resp_misr

Overview:
- BIST response analyser placed directly downstream of the s27 benchmark core; it consumes the single observable output G17 on every CK edge.
- After a programmable settle window, it compacts N consecutive G17 samples into a W-bit multiple-input signature register (MISR).
- It then compares the signature against a golden value and reports pass/fail to the test harness.

Parameters:
- W, 16, MISR width in bits (legal range 2..32).
- POLY, 16'h002D, feedback tap mask, XORed in when the MISR MSB is 1.
- SEED, 0, signature value loaded on each start.
- N, 64, number of response samples compacted (legal range 1..2^20).
- SKIP, 3, number of settle cycles ignored after start (legal range 0..255); covers s27 flip-flop initialisation.

Ports:
- CK, in, 1, clock, rising edge.
- RN, in, 1, asynchronous active-low reset.
- START, in, 1, single-cycle request to begin a run; sampled only in IDLE or DONE.
- ABORT, in, 1, returns the block to IDLE from any state.
- G17, in, 1, response bit from the s27 core.
- GOLDEN, in, W, expected signature; must be stable from START until DONE.
- BUSY, out, 1, high in SETTLE or RUN.
- DONE, out, 1, high in the DONE state.
- PASS, out, 1, registered compare result; valid only while DONE=1.
- SIG, out, W, current MISR contents.

Behaviour:
- Reset (RN=0, asynchronous): state=IDLE, BUSY=0, DONE=0, PASS=0, SIG=SEED, counters=0.
- Reset asserted mid-run aborts the run with no residual state.
- States: IDLE, SETTLE, RUN, DONE.
  - BUSY = (state==SETTLE or state==RUN), decoded from the state register (registered, glitch-free).
  - DONE = (state==DONE).
- IDLE or DONE with START=1 at an edge:
  - SIG<=SEED, PASS<=0, cnt<=0.
  - Next state is SETTLE if SKIP>0, otherwise RUN.
- SETTLE: cnt increments each edge and G17 is ignored. At the edge where cnt==SKIP-1: cnt<=0 and state<=RUN.
- RUN: on each edge, let fb=SIG[W-1].
  - SIG <= (SIG<<1, truncated to W bits) XOR (fb ? POLY : 0) XOR {0...,G17}; G17 enters bit 0.
  - cnt increments each edge.
  - At the edge where cnt==N-1: state<=DONE and PASS<=(next SIG==GOLDEN).
- Latency: G17 is sampled on exactly N edges. DONE rises SKIP+N edges after the edge that samples START.
- DONE: SIG and PASS hold until START (restart) or ABORT.
- START while BUSY is ignored and does not restart the run.
- ABORT=1 at an edge from any state:
  - state<=IDLE, PASS<=0, cnt<=0, SIG holds its value.
  - ABORT has priority over START and over the RUN→DONE transition.
- Simultaneous START and ABORT: ABORT wins.
- cnt width is ceil(log2(max(N,SKIP)))+1. No counter wraps within a run.
- All logic is synchronous to CK apart from RN. There are no combinational paths from inputs to outputs.

Test Plan:
- W=4, POLY=4'h3, SEED=0, SKIP=0, N=4; START, then G17=1,0,1,1 on successive RUN edges → SIG sequence 1,2,5,B; DONE=1 on the 4th edge after the START edge; GOLDEN=4'hB gives PASS=1, GOLDEN=4'hA gives PASS=0.
- Same parameters with N=5 and G17=1,1,1,1,1 → SIG 1,3,7,F,C (feedback applied at step 5); PASS=1 with GOLDEN=4'hC.
- SKIP=3, N=4: G17 driven 1 during SETTLE and 0 during RUN → final SIG=0; BUSY high for exactly 7 cycles; DONE rises 7 edges after START.
- ABORT asserted on RUN cycle 2 → next cycle IDLE, BUSY=0, DONE=0; START pulsed during BUSY before the abort has no effect.
- RN pulsed low mid-RUN, asynchronously between edges → BUSY=0 and SIG=SEED immediately; a new START then yields the full correct signature.
- Back-to-back runs: START asserted while DONE=1 → SIG reloads SEED, PASS clears, and the second run's signature matches the first for identical stimulus.
